// File: rtl/sd_wb_port_if.sv
// Bus bundle between the CPU MMIO decode, the write-back port and the SD cache controller.
// The port itself uses the slave modport; the CPU/controller side uses the master modport.
interface sd_wb_port_if;
  logic [31:0] wdata;
  logic        sd_wb_addr_we;
  logic        sd_wb_control_we;
  logic        sd_wb_wdata_we;
  logic        sd_wb_req;
  logic [31:0] sd_wb_addr;
  logic [31:0] sd_wb_data;
  logic        sd_wb_ack;
  logic        sd_wb_done;
  logic [31:0] status;

  modport slave (
    input  wdata, sd_wb_addr_we, sd_wb_control_we, sd_wb_wdata_we, sd_wb_ack, sd_wb_done,
    output sd_wb_req, sd_wb_addr, sd_wb_data, status
  );

  modport master (
    output wdata, sd_wb_addr_we, sd_wb_control_we, sd_wb_wdata_we, sd_wb_ack, sd_wb_done,
    input  sd_wb_req, sd_wb_addr, sd_wb_data, status
  );
endinterface

// File: rtl/sd_wb_port.sv
// MMIO-programmed write-back port: CPU loads address/data, starts a transfer, controller acks words.
// Define SD_WB_BURST_EN to replace the single data register with an 8-entry FIFO and burst lengths 1..8.
module sd_wb_port (
  input  logic          clk,
  input  logic          rst_n,
  sd_wb_port_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [3:0]  remain_q, remain_d;

  logic        isIdle;
  logic        push;
  logic        pop;
  logic        storeFull;
  logic        startReady;
  logic [3:0]  wordCount;
  logic [3:0]  burstLen;
  logic [31:0] headData;

`ifdef SD_WB_BURST_EN
  logic [31:0] fifo_q [8];
  logic [2:0]  wrPtr_q, rdPtr_q;
  logic [3:0]  count_q;

  assign burstLen   = {1'b0, bus.wdata[6:4]} + 4'd1;
  assign wordCount  = count_q;
  assign storeFull  = (count_q == 4'd8);
  assign startReady = (count_q >= burstLen);
  assign headData   = (count_q == 4'd0) ? 32'd0 : fifo_q[rdPtr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= 3'd0;
      rdPtr_q <= 3'd0;
      count_q <= 4'd0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 3'd1;
      if (pop)  rdPtr_q <= rdPtr_q + 3'd1;
      count_q <= count_q + {3'd0, push} - {3'd0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wrPtr_q] <= bus.wdata;
  end
`else
  logic [31:0] dataReg_q;
  logic        dataValid_q;

  assign burstLen   = 4'd1;
  assign wordCount  = {3'd0, dataValid_q};
  assign storeFull  = 1'b0;
  assign startReady = 1'b1;
  assign headData   = dataReg_q;

  // The data register keeps its value after a transfer; only the "word pending" flag is consumed by the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataReg_q   <= 32'd0;
      dataValid_q <= 1'b0;
    end else begin
      if (push) begin
        dataReg_q   <= bus.wdata;
        dataValid_q <= 1'b1;
      end else if (pop) begin
        dataValid_q <= 1'b0;
      end
    end
  end
`endif

  assign isIdle = (state_q == IDLE);

  // Clear is handled before every other error source so clear+start in one write behaves as clear-then-start.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    done_d   = done_q;
    err_d    = err_q;
    remain_d = remain_q;
    push     = 1'b0;
    pop      = 1'b0;

    if (bus.sd_wb_control_we && bus.wdata[1]) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    if (bus.sd_wb_addr_we) begin
      if (isIdle) addr_d = bus.wdata;
      else        err_d  = 1'b1;
    end

    if (bus.sd_wb_wdata_we) begin
      if (!isIdle || storeFull) err_d = 1'b1;
      else                      push  = 1'b1;
    end

    if (bus.sd_wb_control_we && bus.wdata[0]) begin
      if (!isIdle || !startReady) begin
        err_d = 1'b1;
      end else begin
        done_d   = 1'b0;
        remain_d = burstLen;
        state_d  = REQ;
      end
    end

    unique case (state_q)
      REQ: begin
        if (bus.sd_wb_ack) begin
          pop      = 1'b1;
          addr_d   = addr_q + 32'd4;
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) begin
            if (bus.sd_wb_done) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (bus.sd_wb_done) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      remain_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      done_q   <= done_d;
      err_q    <= err_d;
      remain_q <= remain_d;
    end
  end

  assign bus.sd_wb_req  = (state_q == REQ);
  assign bus.sd_wb_addr = addr_q;
  assign bus.sd_wb_data = headData;
  assign bus.status     = {24'd0, wordCount, 1'b0, err_q, done_q, !isIdle};

endmodule

// File: tb/tb_sd_wb_port.sv
// Directed bench for sd_wb_port: inputs change on the falling edge, outputs are checked there too.
// Burst-only steps are compiled in when SD_WB_BURST_EN is defined.
module tb_sd_wb_port;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_DATA = 5'b00001;
  localparam logic [4:0] S_CTRL = 5'b00010;
  localparam logic [4:0] S_ADDR = 5'b00100;
  localparam logic [4:0] S_DONE = 5'b01000;
  localparam logic [4:0] S_ACK  = 5'b10000;

`ifdef SD_WB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  sd_wb_port_if bus ();

  sd_wb_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds the requested strobes for exactly one rising edge, returning on the following falling edge.
  task automatic applyStimulus(input logic [4:0] strobes, input logic [31:0] data);
    bus.wdata            = data;
    bus.sd_wb_wdata_we   = strobes[0];
    bus.sd_wb_control_we = strobes[1];
    bus.sd_wb_addr_we    = strobes[2];
    bus.sd_wb_done       = strobes[3];
    bus.sd_wb_ack        = strobes[4];
    @(negedge clk);
    bus.sd_wb_wdata_we   = 1'b0;
    bus.sd_wb_control_we = 1'b0;
    bus.sd_wb_addr_we    = 1'b0;
    bus.sd_wb_done       = 1'b0;
    bus.sd_wb_ack        = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    bus.wdata            = 32'd0;
    bus.sd_wb_addr_we    = 1'b0;
    bus.sd_wb_control_we = 1'b0;
    bus.sd_wb_wdata_we   = 1'b0;
    bus.sd_wb_ack        = 1'b0;
    bus.sd_wb_done       = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_req",    {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("reset_addr",   bus.sd_wb_addr, 32'd0);
    checkOutput("reset_data",   bus.sd_wb_data, 32'd0);
    checkOutput("reset_status", bus.status,     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single transfer: ack in the 4th req cycle, done a few cycles later.
    applyStimulus(S_ADDR, 32'h0000_1000);
    checkOutput("single_addr_idle", bus.sd_wb_addr, 32'h0000_1000);
    applyStimulus(S_DATA, 32'hDEAD_BEEF);
    checkOutput("single_status_loaded", bus.status, 32'h0000_0010);
    applyStimulus(S_CTRL, 32'h0000_0001);
    checkOutput("single_req_c1",  {31'd0, bus.sd_wb_req}, 32'd1);
    checkOutput("single_status_busy", bus.status, 32'h0000_0011);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(S_NONE, 32'd0);
      checkOutput("single_req_hold", {31'd0, bus.sd_wb_req}, 32'd1);
      checkOutput("single_addr_hold", bus.sd_wb_addr, 32'h0000_1000);
      checkOutput("single_data_hold", bus.sd_wb_data, 32'hDEAD_BEEF);
    end
    applyStimulus(S_ACK, 32'd0);
    checkOutput("single_req_after_ack", {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("single_status_wait", bus.status, 32'h0000_0001);
    checkOutput("single_addr_next", bus.sd_wb_addr, 32'h0000_1004);
    applyStimulus(S_NONE, 32'd0);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("single_status_done", bus.status, 32'h0000_0002);

    // Busy violations during WAIT must be flagged but leave the transfer untouched.
    applyStimulus(S_DATA, 32'hCAFE_F00D);
    checkOutput("busy_status_loaded", bus.status, 32'h0000_0012);
    applyStimulus(S_CTRL, 32'h0000_0001);
    checkOutput("busy_status_started", bus.status, 32'h0000_0011);
    checkOutput("busy_data_req", bus.sd_wb_data, 32'hCAFE_F00D);
    applyStimulus(S_ACK, 32'd0);
    applyStimulus(S_DATA, 32'h1234_5678);
    checkOutput("busy_data_unchanged", bus.sd_wb_data, BURST ? 32'd0 : 32'hCAFE_F00D);
    checkOutput("busy_status_err", bus.status, 32'h0000_0005);
    applyStimulus(S_CTRL, 32'h0000_0001);
    checkOutput("busy_start_ignored_req", {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("busy_start_status", bus.status, 32'h0000_0005);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("busy_done_status", bus.status, 32'h0000_0006);
    applyStimulus(S_NONE, 32'd0);
    checkOutput("busy_single_only", {31'd0, bus.sd_wb_req}, 32'd0);
    applyStimulus(S_CTRL, 32'h0000_0002);
    checkOutput("busy_clear_status", bus.status, 32'h0000_0000);

    // Stray ack and done in IDLE change nothing.
    applyStimulus(S_ACK, 32'd0);
    checkOutput("stray_ack_status", bus.status, 32'h0000_0000);
    checkOutput("stray_ack_addr", bus.sd_wb_addr, 32'h0000_1008);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("stray_done_status", bus.status, 32'h0000_0000);

    // Same-cycle ack and done on the last word returns straight to IDLE.
    applyStimulus(S_DATA, 32'h0BAD_F00D);
    applyStimulus(S_CTRL, 32'h0000_0001);
    checkOutput("combo_req", {31'd0, bus.sd_wb_req}, 32'd1);
    applyStimulus(S_ACK | S_DONE, 32'd0);
    checkOutput("combo_status", bus.status, 32'h0000_0002);
    checkOutput("combo_req_low", {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("combo_addr", bus.sd_wb_addr, 32'h0000_100C);

    // Clear+start in one write; a done in REQ without ack is ignored. Without bursts, bits[6:4] are ignored.
    applyStimulus(S_DATA, 32'h600D_CAFE);
    checkOutput("clrstart_loaded", bus.status, 32'h0000_0012);
    applyStimulus(S_CTRL, BURST ? 32'h0000_0003 : 32'h0000_0073);
    checkOutput("clrstart_status", bus.status, 32'h0000_0011);
    checkOutput("clrstart_data", bus.sd_wb_data, 32'h600D_CAFE);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("req_done_ignored", {31'd0, bus.sd_wb_req}, 32'd1);
    checkOutput("req_done_status", bus.status, 32'h0000_0011);
    applyStimulus(S_ACK, 32'd0);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("clrstart_done", bus.status, 32'h0000_0002);

    // Reset while req is high abandons the transfer immediately.
    applyStimulus(S_DATA, 32'h55AA_55AA);
    applyStimulus(S_CTRL, 32'h0000_0001);
    checkOutput("rst_mid_req_before", {31'd0, bus.sd_wb_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_req",    {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("rst_async_status", bus.status, 32'h0000_0000);
    checkOutput("rst_async_addr",   bus.sd_wb_addr, 32'd0);
    checkOutput("rst_async_data",   bus.sd_wb_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(S_ACK, 32'd0);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("rst_after_req",    {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("rst_after_status", bus.status, 32'h0000_0000);

`ifdef SD_WB_BURST_EN
    // Four-word burst wrapping past 2^32, words in FIFO order.
    applyStimulus(S_ADDR, 32'hFFFF_FFF8);
    applyStimulus(S_DATA, 32'h1111_1111);
    applyStimulus(S_DATA, 32'h2222_2222);
    applyStimulus(S_DATA, 32'h3333_3333);
    applyStimulus(S_DATA, 32'h4444_4444);
    checkOutput("burst_count4", bus.status, 32'h0000_0040);
    applyStimulus(S_CTRL, 32'h0000_0031);
    checkOutput("burst_w0_addr", bus.sd_wb_addr, 32'hFFFF_FFF8);
    checkOutput("burst_w0_data", bus.sd_wb_data, 32'h1111_1111);
    applyStimulus(S_ACK, 32'd0);
    checkOutput("burst_w1_addr", bus.sd_wb_addr, 32'hFFFF_FFFC);
    checkOutput("burst_w1_data", bus.sd_wb_data, 32'h2222_2222);
    applyStimulus(S_ACK, 32'd0);
    checkOutput("burst_w2_addr", bus.sd_wb_addr, 32'h0000_0000);
    checkOutput("burst_w2_data", bus.sd_wb_data, 32'h3333_3333);
    applyStimulus(S_ACK, 32'd0);
    checkOutput("burst_w3_addr", bus.sd_wb_addr, 32'h0000_0004);
    checkOutput("burst_w3_data", bus.sd_wb_data, 32'h4444_4444);
    checkOutput("burst_w3_req", {31'd0, bus.sd_wb_req}, 32'd1);
    applyStimulus(S_ACK, 32'd0);
    checkOutput("burst_end_req", {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("burst_end_status", bus.status, 32'h0000_0001);
    applyStimulus(S_DONE, 32'd0);
    checkOutput("burst_done", bus.status, 32'h0000_0002);
    applyStimulus(S_CTRL, 32'h0000_0002);

    // Underflow rejects the start; overflow drops the ninth word.
    applyStimulus(S_DATA, 32'hA000_0001);
    applyStimulus(S_DATA, 32'hA000_0002);
    applyStimulus(S_CTRL, 32'h0000_0071);
    checkOutput("under_req", {31'd0, bus.sd_wb_req}, 32'd0);
    checkOutput("under_status", bus.status, 32'h0000_0024);
    for (int i = 0; i < 7; i++) applyStimulus(S_DATA, 32'hB000_0000 + i);
    checkOutput("over_status", bus.status, 32'h0000_0084);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
